// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the single-cycle MIPS core.
//
// Selects the next fetch address each cycle from the hold, jump-register,
// jump, branch and sequential sources. A run-state machine handles boot,
// halt/resume and misaligned jump-register faults. Also keeps a
// retired-instruction counter and the exception PC.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start/halt/resume   run-state control
//   stall               hold the current PC this cycle
//   branch, branch_imm  taken branch and its signed word offset
//   jump, jump_index    j/jal and its 26-bit instruction index
//   jump_reg, reg_addr  jr/jalr and its register target
//   pc_out_addr         current PC read back from program_counter
//   pc_in_addr          next PC to program_counter (combinational)
//   running/halted/fault  decoded run state
//   epc                 PC of the last faulting jr
//   retired             retired-instruction count (wraps)
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] FAULT_ADDR = 32'h0000_0180
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    input  logic        resume,
    input  logic        stall,
    input  logic        branch,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] reg_addr,
    input  logic [31:0] pc_out_addr,
    output logic [31:0] pc_in_addr,
    output logic        running,
    output logic        halted,
    output logic        fault,
    output logic [31:0] epc,
    output logic [31:0] retired
);

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                epc_load;
    logic                retire;
    logic [ADDR_W-1:0]   pc4;
    logic [ADDR_W-1:0]   branch_offset;
    logic [ADDR_W-1:0]   branch_target;
    logic [ADDR_W-1:0]   jump_target;
    logic [ADDR_W-1:0]   run_target;
    logic                misaligned_jr;

    // Redirect target arithmetic; all sums wrap modulo 2^32
    always_comb begin
        pc4           = pc_out_addr + ADDR_W'(4);
        branch_offset = {{14{branch_imm[15]}}, branch_imm, 2'b00};
        branch_target = pc4 + branch_offset;
        jump_target   = {pc4[31:28], jump_index, 2'b00};
    end

    // A stalled jr has not executed yet, so it cannot fault
    assign misaligned_jr = jump_reg && !stall && (reg_addr[1:0] != 2'b00);

    // Normal RUN-state source priority: stall > jr > jump > branch > pc4
    always_comb begin
        run_target = pc4;
        if (stall) begin
            run_target = pc_out_addr;
        end else if (jump_reg) begin
            run_target = reg_addr;
        end else if (jump) begin
            run_target = jump_target;
        end else if (branch) begin
            run_target = branch_target;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, next-PC and register-enable decode
    always_comb begin
        next_state = state;
        pc_in_addr = pc_out_addr;
        epc_load   = 1'b0;
        retire     = 1'b0;

        if (reset) begin
            next_state = ST_IDLE;
            pc_in_addr = RESET_ADDR;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    pc_in_addr = RESET_ADDR;
                    if (start) begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Fault beats halt; halt beats every redirect
                    if (misaligned_jr) begin
                        pc_in_addr = FAULT_ADDR;
                        epc_load   = 1'b1;
                        next_state = ST_FAULT;
                    end else if (halt) begin
                        pc_in_addr = pc_out_addr;
                        next_state = ST_HALTED;
                    end else begin
                        pc_in_addr = run_target;
                        retire     = !stall;
                    end
                end
                ST_HALTED: begin
                    pc_in_addr = pc_out_addr;
                    if (resume && !halt) begin
                        next_state = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    pc_in_addr = pc_out_addr;
                    if (start) begin
                        next_state = ST_RUN;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    pc_in_addr = RESET_ADDR;
                end
            endcase
        end
    end

    // Exception PC: captures the PC of the faulting jr
    always_ff @(posedge clock) begin
        if (reset) begin
            epc <= '0;
        end else if (epc_load) begin
            epc <= pc_out_addr;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clock) begin
        if (reset) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + ADDR_W'(1);
        end
    end

    // Run-state decode
    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);
    assign fault   = (state == ST_FAULT);

endmodule
